// File: rtl/context_checker_if.sv
// Operand/result stream and verdict stream bundle for context_checker.
interface context_checker_if #(
    parameter int unsigned NX = 8,
    parameter int unsigned CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [NX-1:0] a;
    logic [NX-1:0] b;
    logic [NX-1:0] xout;
    logic          out_valid;
    logic          out_ready;
    logic          match;
    logic          div_zero;
    logic [NX-1:0] expected;
    logic [NX-1:0] acc;
    logic [CW-1:0] err_count;
    logic [CW-1:0] txn_count;

    modport master (
        output in_valid, a, b, xout, out_ready,
        input  in_ready, out_valid, match, div_zero, expected, acc, err_count, txn_count
    );

    modport slave (
        input  in_valid, a, b, xout, out_ready,
        output in_ready, out_valid, match, div_zero, expected, acc, err_count, txn_count
    );
endinterface

// File: rtl/context_checker.sv
// Recomputes (A-B)+A*B for each triple, divides A by B with a restoring divider,
// accumulates the quotients and reports a match verdict with saturating counters.
module context_checker #(
    parameter int unsigned NX = 8,
    parameter int unsigned CW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    context_checker_if.slave   bus
);
    localparam int unsigned SW = (NX > 1) ? $clog2(NX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [NX-1:0] dvd_q, dvd_d;
    logic [NX-1:0] b_q, b_d;
    logic [NX-1:0] xout_q, xout_d;
    logic [NX-1:0] calc_q, calc_d;
    logic [NX-1:0] rem_q, rem_d;
    logic [NX-1:0] quo_q, quo_d;
    logic [SW-1:0] step_q, step_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          match_q, match_d;
    logic          div_zero_q, div_zero_d;
    logic [NX-1:0] expected_q, expected_d;
    logic [NX-1:0] acc_q, acc_d;
    logic [CW-1:0] err_q, err_d;
    logic [CW-1:0] txn_q, txn_d;

    logic [NX-1:0] calc_c;
    logic [NX:0]   rem_shift_c;
    logic [NX:0]   rem_sub_c;
    logic          rem_ge_c;
    logic [NX-1:0] quo_next_c;

    // Restoring division step: shift next dividend bit into the partial remainder.
    always_comb begin
        calc_c      = (bus.a - bus.b) + (bus.a * bus.b);
        rem_shift_c = {rem_q, dvd_q[NX-1]};
        rem_ge_c    = (rem_shift_c >= {1'b0, b_q});
        rem_sub_c   = rem_shift_c - {1'b0, b_q};
        quo_next_c  = NX'({quo_q, rem_ge_c});
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        b_d         = b_q;
        xout_d      = xout_q;
        calc_d      = calc_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        match_d     = match_q;
        div_zero_d  = div_zero_q;
        expected_d  = expected_q;
        acc_d       = acc_q;
        err_d       = err_q;
        txn_d       = txn_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    dvd_d      = bus.a;
                    b_d        = bus.b;
                    xout_d     = bus.xout;
                    calc_d     = calc_c;
                    rem_d      = '0;
                    quo_d      = '0;
                    step_d     = '0;
                    in_ready_d = 1'b0;
                    if (bus.b == '0) begin
                        // Division by zero: quotient is all ones, skip the divider.
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        expected_d  = calc_c;
                        match_d     = (bus.xout == calc_c);
                        div_zero_d  = 1'b1;
                        acc_d       = acc_q + {NX{1'b1}};
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                rem_d  = rem_ge_c ? NX'(rem_sub_c) : NX'(rem_shift_c);
                quo_d  = quo_next_c;
                dvd_d  = dvd_q << 1;
                step_d = step_q + SW'(1);
                if (step_q == SW'(NX - 1)) begin
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    expected_d  = calc_q;
                    match_d     = (xout_q == calc_q);
                    div_zero_d  = 1'b0;
                    acc_d       = acc_q + quo_next_c;
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    if (txn_q != {CW{1'b1}}) txn_d = txn_q + CW'(1);
                    if (!match_q && (err_q != {CW{1'b1}})) err_d = err_q + CW'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            b_q         <= '0;
            xout_q      <= '0;
            calc_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            match_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            expected_q  <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            b_q         <= b_d;
            xout_q      <= xout_d;
            calc_q      <= calc_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            match_q     <= match_d;
            div_zero_q  <= div_zero_d;
            expected_q  <= expected_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            txn_q       <= txn_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.match     = match_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.expected  = expected_q;
    assign bus.acc       = acc_q;
    assign bus.err_count = err_q;
    assign bus.txn_count = txn_q;
endmodule

// File: tb/tb_context_checker.sv
// Self-checking bench for context_checker: directed table, backpressure, async reset,
// counter saturation (second instance with CW=2) and randomized traffic vs. a model.
module tb_context_checker;
    localparam int NX   = 8;
    localparam int MASK = (1 << NX) - 1;

    typedef struct {
        int a; int b; int x;
        int e; int m; int dz; int acc; int lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    context_checker_if #(.NX(NX), .CW(16)) bus ();
    context_checker_if #(.NX(NX), .CW(2))  sbus ();

    assign sbus.in_valid  = bus.in_valid;
    assign sbus.a         = bus.a;
    assign sbus.b         = bus.b;
    assign sbus.xout      = bus.xout;
    assign sbus.out_ready = bus.out_ready;

    context_checker #(.NX(NX), .CW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    context_checker #(.NX(NX), .CW(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    int total = 0;
    int bad = 0;
    int m_acc = 0, m_err = 0, m_txn = 0;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic straight from the defining formulas.
    function automatic void model(input int a, input int b, input int x,
                                  output int e, output int m, output int dz, output int q);
        e  = ((a - b) + a * b) & MASK;
        m  = (x == e) ? 1 : 0;
        dz = (b == 0) ? 1 : 0;
        q  = (b == 0) ? MASK : a / b;
    endfunction

    task automatic send(input int a, input int b, input int x);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = NX'(a); bus.b = NX'(b); bus.xout = NX'(x);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input int e, input int m, input int dz, input int acc);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_expected"}, int'(bus.expected), e);
        chk({tag, "_match"}, int'(bus.match), m);
        chk({tag, "_div_zero"}, int'(bus.div_zero), dz);
        chk({tag, "_acc"}, int'(bus.acc), acc);
    endtask

    task automatic ack(input int m);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        m_txn++;
        if (m == 0) m_err++;
        chk("ack_out_valid", int'(bus.out_valid), 0);
        chk("ack_in_ready", int'(bus.in_ready), 1);
        chk("txn_count", int'(bus.txn_count), m_txn);
        chk("err_count", int'(bus.err_count), m_err);
        chk("sat_txn_count", int'(sbus.txn_count), (m_txn > 3) ? 3 : m_txn);
        chk("sat_err_count", int'(sbus.err_count), (m_err > 3) ? 3 : m_err);
    endtask

    task automatic run_txn(input string tag, input int a, input int b, input int x, input int hold);
        int e, m, dz, q, lat;
        model(a, b, x, e, m, dz, q);
        m_acc = (m_acc + q) & MASK;
        send(a, b, x);
        chk({tag, "_busy_in_ready"}, int'(bus.in_ready), 0);
        wait_resp(lat);
        chk({tag, "_latency"}, lat, (b == 0) ? 1 : NX + 1);
        check_out(tag, e, m, dz, m_acc);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_expected"}, int'(bus.expected), e);
        end
        ack(m);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_match", int'(bus.match), 0);
        chk("rst_div_zero", int'(bus.div_zero), 0);
        chk("rst_expected", int'(bus.expected), 0);
        chk("rst_acc", int'(bus.acc), 0);
        chk("rst_err_count", int'(bus.err_count), 0);
        chk("rst_txn_count", int'(bus.txn_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0; m_err = 0; m_txn = 0;
    endtask

    initial begin
        int lat, e1, m1, dz1, q1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.xout = '0; bus.out_ready = 1'b0;

        tbl[0] = '{20, 3, 77, 77, 1, 0, 6, 9};
        tbl[1] = '{7, 0, 7, 7, 1, 1, 5, 1};
        tbl[2] = '{200, 100, 0, 132, 0, 0, 7, 9};
        tbl[3] = '{255, 255, 1, 1, 1, 0, 8, 9};
        tbl[4] = '{0, 5, 3, 251, 0, 0, 8, 9};
        tbl[5] = '{9, 2, 25, 25, 1, 0, 12, 9};
        tbl[6] = '{0, 0, 0, 0, 1, 1, 11, 1};

        apply_reset();

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].x);
            wait_resp(lat);
            chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
            check_out($sformatf("t%0d", i), tbl[i].e, tbl[i].m, tbl[i].dz, tbl[i].acc);
            m_acc = tbl[i].acc;
            ack(tbl[i].m);
        end

        // Backpressure: verdict held 20 cycles while a new triple is offered.
        model(50, 7, 0, e1, m1, dz1, q1);
        m_acc = (m_acc + q1) & MASK;
        send(50, 7, 0);
        wait_resp(lat);
        chk("bp_latency", lat, NX + 1);
        check_out("bp", e1, m1, dz1, m_acc);
        bus.in_valid = 1'b1; bus.a = 8'd13; bus.b = 8'd13; bus.xout = 8'd0;
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_expected", int'(bus.expected), e1);
            chk("bp_acc", int'(bus.acc), m_acc);
        end
        ack(m1);
        run_txn("bp2", 13, 13, 0, 0);

        // Asynchronous reset four cycles into the divider.
        send(255, 1, 0);
        repeat (3) @(negedge clk);
        apply_reset();
        run_txn("post_rst", 255, 1, 0, 0);
        chk("post_rst_acc_abs", int'(bus.acc), 255);
        chk("post_rst_exp_abs", int'(bus.expected), 253);

        // Saturation of the CW=2 instance.
        for (int i = 0; i < 4; i++) run_txn("sat", 10, 3, 0, 0);
        chk("sat_err_final", int'(sbus.err_count), 3);
        chk("sat_txn_final", int'(sbus.txn_count), 3);
        chk("main_err_final", int'(bus.err_count), 5);

        for (int i = 0; i < 150; i++) begin
            int a, b, x, e, m, dz, q;
            a = int'($urandom_range(0, MASK));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MASK));
            model(a, b, 0, e, m, dz, q);
            x = ($urandom_range(0, 1) == 1) ? e : int'($urandom_range(0, MASK));
            run_txn("rnd", a, b, x, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
